// File: rtl/sp_usb_fifo_device_pkg.sv
// Shared definitions for the FT245-style device model.
//   BYTE_W      : bus and FIFO byte width
//   byte_t      : one bus byte
//   rd_state_t  : read-side FSM encoding
package sp_usb_fifo_device_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_DRIVE = 2'd2,
        R_HOLD  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sp_usb_fifo_device_byte_fifo.sv
// Synchronous byte FIFO with power-of-two depth.
//   clk, rst_n : clock, async active-low reset (clears pointers only)
//   push, din  : write din when not full
//   pop        : advance head when not empty
//   dout       : current head entry
//   full/empty : occupancy flags derived from the extra pointer bit
module sp_byte_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Pointers wrap naturally through the extra MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/sp_usb_fifo_device.sv
// Device end of an FT245-style async USB FIFO bus.
//   clk, rst_n          : clock, async active-low reset
//   usb_data            : bidirectional byte bus, driven only while reading out
//   rxf_n / txe_n       : byte-available / room-available, active low, registered
//   rd_n / wr_n         : host strobes, active low
//   side_din/side_write : load bytes toward the bus (side_full = rx full)
//   side_dout/side_read : drain bytes written by the bus (side_avail = non-empty)
//   err_under/err_over  : sticky strobe-while-not-ready flags
module sp_usb_fifo_device
    import sp_usb_fifo_device_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RXF_HOLD   = 3,
    parameter int unsigned TXE_HOLD   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [BYTE_W-1:0] usb_data,
    output logic              rxf_n,
    output logic              txe_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [BYTE_W-1:0] side_din,
    input  logic              side_write,
    output logic              side_full,
    output logic [BYTE_W-1:0] side_dout,
    input  logic              side_read,
    output logic              side_avail,
    output logic              err_under,
    output logic              err_over
);

    localparam int unsigned LAT_W  = $clog2(RD_LATENCY + 1);
    localparam int unsigned RH_W   = $clog2(RXF_HOLD + 1);
    localparam int unsigned TH_W   = $clog2(TXE_HOLD + 1);
    localparam int unsigned WAIT_0 = (RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0;

    rd_state_t         rd_state;
    logic              oe;
    byte_t             out_reg;
    logic [LAT_W-1:0]  wait_cnt;
    logic [RH_W-1:0]   rd_hold_cnt;
    logic [TH_W-1:0]   wr_hold_cnt;
    logic              rd_q;
    logic              wr_q;

    logic              rd_fall, rd_rise, wr_fall, wr_rise;
    logic              rd_accept, rx_pop, tx_push;
    logic              rx_empty, tx_empty, tx_full;
    byte_t             rx_dout;

    assign rd_fall   = rd_q & ~rd_n;
    assign rd_rise   = ~rd_q & rd_n;
    assign wr_fall   = wr_q & ~wr_n;
    assign wr_rise   = ~wr_q & wr_n;

    // A concurrent write strobe takes priority; the read is silently dropped
    assign rd_accept = rd_fall & ~rxf_n & wr_n & (rd_state == R_IDLE);
    assign rx_pop    = rd_rise & ((rd_state == R_DRIVE) || (rd_state == R_WAIT));
    assign tx_push   = wr_fall & ~txe_n;

    assign usb_data   = oe ? out_reg : {BYTE_W{1'bz}};
    assign side_avail = ~tx_empty;

    sp_byte_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (side_write),
        .din   (side_din),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (side_full),
        .empty (rx_empty)
    );

    sp_byte_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .din   (usb_data),
        .pop   (side_read),
        .dout  (side_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Read side: strobe edge detect, FSM, precharge hold and underrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= 1'b1;
            rd_state    <= R_IDLE;
            oe          <= 1'b0;
            out_reg     <= '0;
            wait_cnt    <= '0;
            rd_hold_cnt <= '0;
            rxf_n       <= 1'b1;
            err_under   <= 1'b0;
        end else begin
            rd_q  <= rd_n;
            // rd_accept raises rxf_n on the accepting edge itself
            rxf_n <= rx_empty | (rd_state != R_IDLE) | rd_accept;
            if (rd_fall && rxf_n && wr_n) err_under <= 1'b1;

            case (rd_state)
                R_IDLE: begin
                    if (rd_accept) begin
                        out_reg <= rx_dout;
                        if (RD_LATENCY <= 1) begin
                            oe       <= 1'b1;
                            rd_state <= R_DRIVE;
                        end else begin
                            wait_cnt <= LAT_W'(WAIT_0);
                            rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    // An early rise still consumes the byte so the FSM cannot stall
                    if (rd_rise) begin
                        rd_hold_cnt <= RH_W'(RXF_HOLD);
                        rd_state    <= R_HOLD;
                    end else if (wait_cnt == '0) begin
                        oe       <= 1'b1;
                        rd_state <= R_DRIVE;
                    end else begin
                        wait_cnt <= wait_cnt - LAT_W'(1);
                    end
                end
                R_DRIVE: begin
                    if (rd_rise) begin
                        oe          <= 1'b0;
                        rd_hold_cnt <= RH_W'(RXF_HOLD);
                        rd_state    <= R_HOLD;
                    end
                end
                R_HOLD: begin
                    if (rd_hold_cnt == '0) rd_state <= R_IDLE;
                    else                   rd_hold_cnt <= rd_hold_cnt - RH_W'(1);
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Write side: edge detect, txe_n hold after the strobe and overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= 1'b1;
            wr_hold_cnt <= '0;
            txe_n       <= 1'b1;
            err_over    <= 1'b0;
        end else begin
            wr_q  <= wr_n;
            txe_n <= tx_full | ~wr_n | wr_rise | (wr_hold_cnt != '0);
            if (wr_rise)                wr_hold_cnt <= TH_W'(TXE_HOLD);
            else if (wr_hold_cnt != '0) wr_hold_cnt <= wr_hold_cnt - TH_W'(1);
            if (wr_fall && txe_n) err_over <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_usb_fifo_device.sv
// Directed bench for sp_usb_fifo_device: host-side strobe tasks plus side-port helpers.
module tb_sp_usb_fifo_device;

    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned RXF_HOLD   = 3;
    localparam int unsigned TXE_HOLD   = 3;
    localparam int unsigned WAIT_MAX   = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire  [7:0] usb_data;
    logic       rxf_n, txe_n;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [7:0] side_din = 8'h00;
    logic       side_write = 1'b0;
    logic       side_full;
    logic [7:0] side_dout;
    logic       side_read = 1'b0;
    logic       side_avail;
    logic       err_under, err_over;

    logic [7:0] host_data = 8'h00;
    logic       host_oe = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    assign usb_data = host_oe ? host_data : 8'hzz;

    always #5 clk = ~clk;

    sp_usb_fifo_device #(
        .DEPTH_LOG2 (4),
        .RD_LATENCY (RD_LATENCY),
        .RXF_HOLD   (RXF_HOLD),
        .TXE_HOLD   (TXE_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .usb_data   (usb_data),
        .rxf_n      (rxf_n),
        .txe_n      (txe_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .side_din   (side_din),
        .side_write (side_write),
        .side_full  (side_full),
        .side_dout  (side_dout),
        .side_read  (side_read),
        .side_avail (side_avail),
        .err_under  (err_under),
        .err_over   (err_over)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic wait_rxf_low();
        int n = 0;
        while (rxf_n !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("rxf_wait", rxf_n, 0);
    endtask

    task automatic wait_txe_low();
        int n = 0;
        while (txe_n !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("txe_wait", txe_n, 0);
    endtask

    task automatic side_push(input logic [7:0] d);
        @(negedge clk);
        side_din   = d;
        side_write = 1'b1;
        @(negedge clk);
        side_write = 1'b0;
    endtask

    task automatic side_pop(output logic [7:0] d);
        @(negedge clk);
        d         = side_dout;
        side_read = 1'b1;
        @(negedge clk);
        side_read = 1'b0;
    endtask

    // Host read cycle; optionally pushes a side byte on the clock that pops
    task automatic bus_read(output logic [7:0] d, input bit push_on_rise, input logic [7:0] pv);
        wait_rxf_low();
        @(negedge clk);
        rd_n = 1'b0;
        repeat (RD_LATENCY + 1) @(negedge clk);
        d    = usb_data;
        rd_n = 1'b1;
        if (push_on_rise) begin
            side_din   = pv;
            side_write = 1'b1;
        end
        for (int i = 0; i < int'(RXF_HOLD); i++) begin
            @(negedge clk);
            side_write = 1'b0;
            check("rxf_hold", rxf_n, 1);
        end
    endtask

    // Host write cycle; force_strobe skips the txe_n handshake
    task automatic bus_write(input logic [7:0] d, input bit force_strobe);
        if (!force_strobe) wait_txe_low();
        @(negedge clk);
        host_data = d;
        host_oe   = 1'b1;
        wr_n      = 1'b0;
        repeat (2) @(negedge clk);
        wr_n = 1'b1;
        for (int i = 0; i < int'(TXE_HOLD); i++) begin
            @(negedge clk);
            check("txe_hold", txe_n, 1);
        end
        host_oe = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rxf_n", rxf_n, 1);
        check("rst_txe_n", txe_n, 1);
        check("rst_avail", side_avail, 0);
        check("rst_full", side_full, 0);
        check("rst_err_under", err_under, 0);
        check("rst_err_over", err_over, 0);
        check("rst_oe", dut.oe, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_txe_n", txe_n, 0);
        check("rel_rxf_n", rxf_n, 1);

        // Two bus reads of side-loaded bytes
        side_push(8'hA5);
        side_push(8'h3C);
        bus_read(d, 1'b0, 8'h00);
        check("rd0", d, 8'hA5);
        bus_read(d, 1'b0, 8'h00);
        check("rd1", d, 8'h3C);
        repeat (10) @(negedge clk);
        check("rd_empty_rxf", rxf_n, 1);

        // Two bus writes drained on the side
        bus_write(8'h11, 1'b0);
        bus_write(8'h22, 1'b0);
        @(negedge clk);
        check("wr_avail", side_avail, 1);
        side_pop(d);
        check("wr0", d, 8'h11);
        side_pop(d);
        check("wr1", d, 8'h22);
        @(negedge clk);
        check("wr_drained", side_avail, 0);

        // Fill the tx FIFO, then overrun it
        for (int i = 0; i < 16; i++) bus_write(8'(i), 1'b0);
        repeat (8) @(negedge clk);
        check("full_txe_n", txe_n, 1);
        check("full_no_err", err_over, 0);
        bus_write(8'h99, 1'b1);
        @(negedge clk);
        check("err_over", err_over, 1);
        for (int i = 0; i < 16; i++) begin
            side_pop(d);
            check("full_data", d, 8'(i));
        end
        @(negedge clk);
        check("over_dropped", side_avail, 0);

        // Read with the rx FIFO empty
        check("pre_err_under", err_under, 0);
        @(negedge clk);
        rd_n = 1'b0;
        repeat (3) @(negedge clk);
        check("err_under", err_under, 1);
        check("under_oe", dut.oe, 0);
        check("under_rxf_n", rxf_n, 1);
        rd_n = 1'b1;
        repeat (8) @(negedge clk);

        // Side push coincides with bus pop
        side_push(8'h00);
        bus_read(d, 1'b1, 8'h01);
        check("same_clk_rd0", d, 8'h00);
        bus_read(d, 1'b0, 8'h00);
        check("same_clk_rd1", d, 8'h01);
        repeat (10) @(negedge clk);
        check("same_clk_empty", rxf_n, 1);

        // Reset while driving the bus
        side_push(8'h42);
        bus_write(8'h77, 1'b0);
        @(negedge clk);
        check("pre_rst_avail", side_avail, 1);
        wait_rxf_low();
        @(negedge clk);
        rd_n = 1'b0;
        repeat (2) @(negedge clk);
        check("drive_oe", dut.oe, 1);
        check("drive_data", usb_data, 8'h42);
        rst_n = 1'b0;
        #1;
        check("mid_rst_oe", dut.oe, 0);
        check("mid_rst_rxf_n", rxf_n, 1);
        check("mid_rst_txe_n", txe_n, 1);
        check("mid_rst_avail", side_avail, 0);
        check("mid_rst_err_under", err_under, 0);
        check("mid_rst_err_over", err_over, 0);
        @(negedge clk);
        rd_n  = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_rxf_n", rxf_n, 1);
        check("post_rst_txe_n", txe_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
